// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the debug display page scheduler.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned NSRC     = 4;
  localparam logic [3:0]  DP_BLANK = 4'b1111;

  function automatic logic [NSRC-1:0] src_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter; searches ptr+1, ptr+2, ptr+3, ptr.
module rr_arb4
  import disp_sched_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [1:0]      ptr,
  output logic            gnt_valid,
  output logic [1:0]      gnt_idx
);

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    for (int k = NSRC; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ptr + 2'(k);
      end
    end
  end

endmodule

// File: rtl/disp_page_sched.sv
// Time-shares the 4-digit hex display among four 32-bit debug sources,
// showing the high then low half-word of the granted source for DWELL cycles each.
module disp_page_sched
  import disp_sched_pkg::*;
#(
  parameter int unsigned          DWELL_W = 24,
  parameter logic [DWELL_W-1:0]   DWELL   = DWELL_W'(24'd12_500_000)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC-1:0]      req,
  input  logic [32*NSRC-1:0]   data,
  input  logic                 hold,
  input  logic                 step,
  output logic [NSRC-1:0]      ack,
  output logic [15:0]          disp_num,
  output logic [3:0]           dp_out,
  output logic                 busy,
  output logic [1:0]           cur_src
);

  localparam logic [DWELL_W-1:0] LAST = DWELL - DWELL_W'(1);

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          word_q, word_d;
  logic [1:0]           cur_src_q, cur_src_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 gnt_valid;
  logic [1:0]           gnt_idx;
  logic                 page_end;

  rr_arb4 u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      cur_src_q <= 2'd0;
      ptr_q     <= 2'd3;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      cur_src_q <= cur_src_d;
      ptr_q     <= ptr_d;
    end
  end

  // step overrides hold; hold only freezes the count, never ends a page.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    cur_src_d = cur_src_q;
    ptr_d     = ptr_q;
    page_end  = step || ((cnt_q == LAST) && !hold);
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          word_d    = data[{gnt_idx, 5'b00000} +: 32];
          cur_src_d = gnt_idx;
          ptr_d     = gnt_idx;
          cnt_d     = '0;
          state_d   = SHOW_HI;
        end
      end
      SHOW_HI, SHOW_LO: begin
        if (page_end) begin
          cnt_d   = '0;
          state_d = (state_q == SHOW_HI) ? SHOW_LO : DONE;
        end else if (!hold) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE keeps the low page on the display while the ack pulses.
  always_comb begin
    disp_num = 16'h0000;
    dp_out   = DP_BLANK;
    ack      = '0;
    busy     = (state_q != IDLE);
    case (state_q)
      SHOW_HI: begin
        disp_num = word_q[31:16];
        dp_out   = ~src_onehot(cur_src_q);
      end
      SHOW_LO: begin
        disp_num = word_q[15:0];
        dp_out   = src_onehot(cur_src_q);
      end
      DONE: begin
        disp_num = word_q[15:0];
        dp_out   = src_onehot(cur_src_q);
        ack      = src_onehot(cur_src_q);
      end
      default: ;
    endcase
  end

  assign cur_src = cur_src_q;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed self-checking bench for disp_page_sched with DWELL=4.
module tb_disp_page_sched;
  import disp_sched_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [127:0]  data;
  logic          hold;
  logic          step;
  logic [3:0]    ack;
  logic [15:0]   disp_num;
  logic [3:0]    dp_out;
  logic          busy;
  logic [1:0]    cur_src;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  typedef struct {
    logic [3:0]  req;
    logic        hold;
    logic        step;
    logic [15:0] disp;
    logic [3:0]  dp;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  src;
  } vec_t;

  vec_t vecs[11];

  disp_page_sched #(
    .DWELL_W (24),
    .DWELL   (24'd4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .hold     (hold),
    .step     (step),
    .ack      (ack),
    .disp_num (disp_num),
    .dp_out   (dp_out),
    .busy     (busy),
    .cur_src  (cur_src)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic h, input logic s);
    req  = r;
    hold = h;
    step = s;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ed, input logic [3:0] edp,
                             input logic [3:0] eack, input logic ebusy, input logic [1:0] esrc);
    total++;
    if (disp_num !== ed || dp_out !== edp || ack !== eack || busy !== ebusy || cur_src !== esrc) begin
      bad++;
      $display("[TB] FAIL %s: got disp=%h dp=%b ack=%b busy=%b src=%0d, want disp=%h dp=%b ack=%b busy=%b src=%0d",
               name, disp_num, dp_out, ack, busy, cur_src, ed, edp, eack, ebusy, esrc);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int last_ack;
    int exp_src;
    int waited;

    data = '0;
    data[31:0]   = 32'h1234ABCD;
    data[63:32]  = 32'h55667788;
    data[95:64]  = 32'hCAFEF00D;
    data[127:96] = 32'h33334444;

    // Single request: 4 high-page cycles, 4 low-page cycles, DONE, IDLE.
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 16'h1234, 4'b1110, 4'b0000, 1'b1, 2'd0};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 16'h1234, 4'b1110, 4'b0000, 1'b1, 2'd0};
    vecs[2]  = '{4'b0001, 1'b0, 1'b0, 16'h1234, 4'b1110, 4'b0000, 1'b1, 2'd0};
    vecs[3]  = '{4'b0001, 1'b0, 1'b0, 16'h1234, 4'b1110, 4'b0000, 1'b1, 2'd0};
    vecs[4]  = '{4'b0001, 1'b0, 1'b0, 16'hABCD, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[5]  = '{4'b0001, 1'b0, 1'b0, 16'hABCD, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[6]  = '{4'b0001, 1'b0, 1'b0, 16'hABCD, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[7]  = '{4'b0001, 1'b0, 1'b0, 16'hABCD, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[8]  = '{4'b0001, 1'b0, 1'b0, 16'hABCD, 4'b0001, 4'b0001, 1'b1, 2'd0};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0};

    doReset();
    checkOutput("reset", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].req, vecs[i].hold, vecs[i].step);
      tick();
      checkOutput($sformatf("single[%0d]", i), vecs[i].disp, vecs[i].dp, vecs[i].ack,
                  vecs[i].busy, vecs[i].src);
    end

    // Round robin with all sources requesting: acks 0,1,2,3,0 spaced 10 cycles.
    doReset();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    last_ack = cycle;
    for (int g = 0; g < 5; g++) begin
      exp_src = g % 4;
      waited  = 0;
      do begin
        tick();
        waited++;
      end while (ack == 4'b0000 && waited < 40);
      if (ack == 4'b0000) begin
        total++;
        bad++;
        $display("[TB] FAIL rr_timeout[%0d]: got no ack within 40 cycles, want ack=%b", g,
                 4'b0001 << exp_src);
        break;
      end
      checkOutput($sformatf("rr_ack[%0d]", g), data[32*exp_src +: 16], 4'b0001 << exp_src,
                  4'b0001 << exp_src, 1'b1, 2'(exp_src));
      total++;
      if ((cycle - last_ack) != ((g == 0) ? 9 : 10)) begin
        bad++;
        $display("[TB] FAIL rr_spacing[%0d]: got %0d cycles, want %0d", g, cycle - last_ack,
                 (g == 0) ? 9 : 10);
      end
      last_ack = cycle;
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rr_idle", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0);

    // Hold freezes the high page; step ends pages even while hold is set.
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    tick();
    checkOutput("hs_hi0", 16'h5566, 4'b1101, 4'b0000, 1'b1, 2'd1);
    tick();
    checkOutput("hs_hi1", 16'h5566, 4'b1101, 4'b0000, 1'b1, 2'd1);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("hs_hold[%0d]", i), 16'h5566, 4'b1101, 4'b0000, 1'b1, 2'd1);
    end
    applyStimulus(4'b0010, 1'b1, 1'b1);
    tick();
    checkOutput("hs_step_lo", 16'h7788, 4'b0010, 4'b0000, 1'b1, 2'd1);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("hs_lo_hold[%0d]", i), 16'h7788, 4'b0010, 4'b0000, 1'b1, 2'd1);
    end
    applyStimulus(4'b0010, 1'b0, 1'b1);
    tick();
    checkOutput("hs_step_done", 16'h7788, 4'b0010, 4'b0010, 1'b1, 2'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("hs_step_in_done", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd1);
    tick();
    checkOutput("hs_step_in_idle", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd1);

    // Data and req change one cycle after the grant; latched word stays.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("dc_hi0", 16'hCAFE, 4'b1011, 4'b0000, 1'b1, 2'd2);
    data[95:64] = 32'h00000000;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput($sformatf("dc_hi[%0d]", i), 16'hCAFE, 4'b1011, 4'b0000, 1'b1, 2'd2);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("dc_lo[%0d]", i), 16'hF00D, 4'b0100, 4'b0000, 1'b1, 2'd2);
    end
    tick();
    checkOutput("dc_done", 16'hF00D, 4'b0100, 4'b0100, 1'b1, 2'd2);
    tick();
    checkOutput("dc_idle", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd2);

    // Reset in the middle of the low page aborts without an ack.
    data[31:0] = 32'h0BADBEEF;
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("rst_lo1", 16'hBEEF, 4'b0001, 4'b0000, 1'b1, 2'd0);
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("rst_abort", 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst_no_ack[%0d]", i), 16'h0000, 4'b1111, 4'b0000, 1'b0, 2'd0);
    end
    applyStimulus(4'b1000, 1'b0, 1'b0);
    tick();
    checkOutput("rst_grant3", 16'h3333, 4'b0111, 4'b0000, 1'b1, 2'd3);

    // After reset source 1 beats source 3 because the search starts at 0.
    doReset();
    applyStimulus(4'b1010, 1'b0, 1'b0);
    tick();
    checkOutput("rst_prio", 16'h5566, 4'b1101, 4'b0000, 1'b1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
